// File: rtl/reg_file_port_ctrl_if.sv
// Command/response stream bundle for reg_file_port_ctrl.
//   cmd_*  : command stream (valid/ready), op 00 read pair, 01 write, 10 dump, 11 reserved
//   rsp_*  : response stream (valid/ready), two data words plus last flag
// master : the command issuer / response consumer
// slave  : the controller
interface reg_file_port_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_waddr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [ADDR_WIDTH-1:0] cmd_raddr1;
  logic [ADDR_WIDTH-1:0] cmd_raddr2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data1;
  logic [DATA_WIDTH-1:0] rsp_data2;
  logic                  rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_waddr, cmd_wdata, cmd_raddr1, cmd_raddr2, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data1, rsp_data2, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_waddr, cmd_wdata, cmd_raddr1, cmd_raddr2, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data1, rsp_data2, rsp_last
  );
endinterface

// File: rtl/reg_file_port_ctrl.sv
// Command-driven initiator for a 2^ADDR_WIDTH x DATA_WIDTH register file
// with one write port and two combinational read ports.
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : command / response streams
//   rf_wen/waddr/wdata : write port (registered)
//   rf_raddr1/2     : read addresses (registered, 0 when not reading)
//   rf_rdata1/2     : combinational read data from the register file
//   busy            : controller not idle
module reg_file_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_file_port_ctrl_if.slave   bus,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RESP, S_DUMP_RD, S_DUMP_RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;

  // Index of the final pair in a dump: 2^ADDR_WIDTH - 2.
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_TWO    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_THREE  = ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] raddr1_q, raddr1_d;
  logic [ADDR_WIDTH-1:0] raddr2_q, raddr2_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;
  logic                  last_q, last_d;
  logic                  accept;

  assign accept = bus.cmd_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      last_q   <= last_d;
    end
  end

  // Read addresses are computed one cycle ahead so they appear registered
  // in RD / DUMP_RD; they fall back to 0 everywhere else.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wen_d    = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    raddr1_d = '0;
    raddr2_d = '0;
    data1_d  = data1_q;
    data2_d  = data2_q;
    last_d   = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (bus.cmd_op)
            OP_READ: begin
              state_d  = S_RD;
              raddr1_d = bus.cmd_raddr1;
              raddr2_d = bus.cmd_raddr2;
            end
            OP_WRITE: begin
              wen_d   = 1'b1;
              waddr_d = bus.cmd_waddr;
              wdata_d = bus.cmd_wdata;
            end
            OP_DUMP: begin
              state_d  = S_DUMP_RD;
              idx_d    = '0;
              raddr1_d = '0;
              raddr2_d = A_ONE;
            end
            default: ; // reserved op: swallowed
          endcase
        end
      end
      S_RD: begin
        data1_d = rf_rdata1;
        data2_d = rf_rdata2;
        last_d  = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      S_DUMP_RD: begin
        data1_d = rf_rdata1;
        data2_d = rf_rdata2;
        last_d  = (idx_q == IDX_LAST);
        state_d = S_DUMP_RESP;
      end
      S_DUMP_RESP: begin
        if (bus.rsp_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d    = idx_q + A_TWO;
            raddr1_d = idx_q + A_TWO;
            raddr2_d = idx_q + A_THREE;
            state_d  = S_DUMP_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP) || (state_q == S_DUMP_RESP);
  assign bus.rsp_data1 = data1_q;
  assign bus.rsp_data2 = data2_q;
  assign bus.rsp_last  = last_q;
  assign busy          = (state_q != S_IDLE);
  assign rf_wen        = wen_q;
  assign rf_waddr      = waddr_q;
  assign rf_wdata      = wdata_q;
  assign rf_raddr1     = raddr1_q;
  assign rf_raddr2     = raddr2_q;

endmodule

// File: tb/tb_reg_file_port_ctrl.sv
module tb_reg_file_port_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr, rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic          busy;

  reg_file_port_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cif ();

  reg_file_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(cif.slave),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file fixture: r0 reads zero, writes to r0 dropped.
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clk) if (rf_wen && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : rf_mem[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == '0) ? '0 : rf_mem[rf_raddr2];

  // Reference: architectural register contents and queue of expected responses.
  typedef struct { logic [DW-1:0] d1; logic [DW-1:0] d2; logic last; } rsp_t;
  logic [DW-1:0] gold [NREG];
  rsp_t          exp_q [$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one command; returns at accept+1 (+#1) after checking that cycle.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    int g = 0;
    cif.cmd_op = op; cif.cmd_waddr = wa; cif.cmd_wdata = wd;
    cif.cmd_raddr1 = a1; cif.cmd_raddr2 = a2; cif.cmd_valid = 1'b1;
    while (!cif.cmd_ready && g < 100) begin step(); g++; end
    chk("cmd_ready_wait", cif.cmd_ready, 1'b1);
    step();
    cif.cmd_valid = 1'b0;
    case (op)
      2'b01: begin
        if (wa != '0) gold[wa] = wd;
        chk("wr_wen", rf_wen, 1'b1);
        chk("wr_waddr", rf_waddr, wa);
        chk("wr_wdata", rf_wdata, wd);
        chk("wr_busy", busy, 1'b0);
      end
      2'b00: begin
        exp_q.push_back('{gold[a1], gold[a2], 1'b1});
        chk("rd_raddr1", rf_raddr1, a1);
        chk("rd_raddr2", rf_raddr2, a2);
        chk("rd_nowen", rf_wen, 1'b0);
        chk("rd_novalid", cif.rsp_valid, 1'b0);
        chk("rd_busy", busy, 1'b1);
      end
      2'b10: begin
        for (int k = 0; k < NREG / 2; k++)
          exp_q.push_back('{gold[2*k], gold[2*k+1], k == NREG / 2 - 1});
        chk("dump_raddr1", rf_raddr1, 0);
        chk("dump_raddr2", rf_raddr2, 1);
        chk("dump_busy", busy, 1'b1);
      end
      default: begin
        chk("rsv_wen", rf_wen, 1'b0);
        chk("rsv_valid", cif.rsp_valid, 1'b0);
        chk("rsv_busy", busy, 1'b0);
        chk("rsv_ready", cif.cmd_ready, 1'b1);
      end
    endcase
  endtask

  // Wait for one response, hold rsp_ready low for 'stall' cycles, then consume it.
  task automatic get_rsp(input int stall);
    int g = 0;
    logic [DW-1:0] h1, h2;
    logic hl;
    rsp_t e;
    while (!cif.rsp_valid && g < 20) begin
      chk("wait_cmd_ready", cif.cmd_ready, busy ? 1'b0 : 1'b1);
      step(); g++;
    end
    chk("rsp_valid_wait", cif.rsp_valid, 1'b1);
    if (exp_q.size() == 0) begin
      chk("rsp_unexpected", cif.rsp_valid, 1'b0);
    end else begin
      chk("rsp_cmd_ready", cif.cmd_ready, 1'b0);
      h1 = cif.rsp_data1; h2 = cif.rsp_data2; hl = cif.rsp_last;
      for (int s = 0; s < stall; s++) begin
        cif.rsp_ready = 1'b0;
        step();
        chk("stall_valid", cif.rsp_valid, 1'b1);
        chk("stall_d1", cif.rsp_data1, h1);
        chk("stall_d2", cif.rsp_data2, h2);
        chk("stall_last", cif.rsp_last, hl);
      end
      cif.rsp_ready = 1'b1;
      e = exp_q.pop_front();
      chk("rsp_d1", cif.rsp_data1, e.d1);
      chk("rsp_d2", cif.rsp_data2, e.d2);
      chk("rsp_last", cif.rsp_last, e.last);
      step();
      cif.rsp_ready = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin rf_mem[i] = '0; gold[i] = '0; end
    cif.cmd_valid = 0; cif.cmd_op = 0; cif.cmd_waddr = 0; cif.cmd_wdata = 0;
    cif.cmd_raddr1 = 0; cif.cmd_raddr2 = 0; cif.rsp_ready = 0;

    // Reset values
    #12;
    chk("rst_ready", cif.cmd_ready, 1'b1);
    chk("rst_valid", cif.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wen", rf_wen, 1'b0);
    chk("rst_raddr", {rf_raddr1, rf_raddr2}, 0);
    chk("rst_data", {cif.rsp_data1, cif.rsp_data2, cif.rsp_last}, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Write r5, then read (5,0); response at accept+2
    send(2'b01, 5, 32'hDEADBEEF, 0, 0);
    send(2'b00, 0, 0, 5, 0);
    step();
    chk("rd_lat_valid", cif.rsp_valid, 1'b1);
    get_rsp(0);
    chk("post_rsp_ready", cif.cmd_ready, 1'b1);
    chk("post_rsp_valid", cif.rsp_valid, 1'b0);

    // Back-to-back writes, then immediate read
    send(2'b01, 1, 32'h11, 0, 0);
    send(2'b01, 2, 32'h22, 0, 0);
    send(2'b00, 0, 0, 1, 2);
    get_rsp(1);

    // Write to r0 is forwarded but discarded
    send(2'b01, 0, 32'h12345678, 0, 0);
    send(2'b00, 0, 0, 0, 0);
    get_rsp(0);

    // Reserved op
    send(2'b11, 3, 32'hFFFF_FFFF, 3, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rsv_quiet", {rf_wen, cif.rsp_valid, busy}, 0);
    end

    // Fill, then dump with rsp_ready toggling
    for (int n = 1; n < NREG; n++) send(2'b01, AW'(n), DW'(n) * 32'h01010101, 0, 0);
    send(2'b10, 0, 0, 0, 0);
    chk("dump_first_gold", exp_q[0].d2, 32'h01010101);
    for (int k = 0; k < NREG / 2; k++) get_rsp(1);
    chk("dump_done_ready", cif.cmd_ready, 1'b1);

    // Randomized traffic against the reference
    for (int it = 0; it < 80; it++) begin
      int sel = $urandom_range(0, 9);
      if (sel < 5) send(2'b01, AW'($urandom), $urandom, 0, 0);
      else if (sel < 9) begin
        send(2'b00, 0, 0, AW'($urandom), AW'($urandom));
        get_rsp($urandom_range(0, 2));
      end else send(2'b11, 0, 0, 0, 0);
    end

    // Reset during the 5th dump response
    send(2'b10, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) get_rsp(0);
    begin
      int g = 0;
      while (!cif.rsp_valid && g < 20) begin step(); g++; end
    end
    chk("pre_rst_valid", cif.rsp_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", cif.rsp_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", cif.cmd_ready, 1'b1);
    chk("arst_data", {cif.rsp_data1, cif.rsp_data2, cif.rsp_last}, 0);
    chk("arst_raddr", {rf_raddr1, rf_raddr2}, 0);
    exp_q.delete();
    cif.rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_valid", cif.rsp_valid, 1'b0);
      chk("post_rst_ready", cif.cmd_ready, 1'b1);
    end
    cif.rsp_ready = 1'b0;

    // Controller still works after reset
    send(2'b00, 0, 0, 5, 1);
    get_rsp(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/reg_file_port_ctrl.md
# reg_file_port_ctrl

Command-driven initiator for the processor's 32×32 register file. It takes read, write and dump commands over a valid/ready stream and sequences them onto the register file's write port and two read ports. Read data is returned over a valid/ready response stream. It sits between debug/test logic (or a microcoded loader) and the register file, and all register-file-facing outputs are registered.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register address width; register count is 2^ADDR_WIDTH
- clk  in  1  sole clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 read pair, 01 write, 10 dump all, 11 reserved
- cmd_waddr  in  ADDR_WIDTH  write address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_raddr1, cmd_raddr2  in  ADDR_WIDTH each  read-pair addresses
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data1, rsp_data2  out  DATA_WIDTH each  read results
- rsp_last  out  1  final response of a dump; 1 for a read-pair response
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- rf_raddr1, rf_raddr2  out  ADDR_WIDTH each  register file read addresses
- rf_rdata1, rf_rdata2  in  DATA_WIDTH each  combinational register file read data
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, RD, RESP, DUMP_RD, DUMP_RESP.
- cmd_ready = (state == IDLE). No command is accepted in any other state.
- Write accepted in IDLE: the next cycle has rf_wen=1 with rf_waddr and rf_wdata registered from the command. The state stays IDLE, so back-to-back writes run at one per cycle. rf_wen is 0 in every cycle that does not follow a write accept.
- Writes to address 0 are forwarded unchanged. The register file discards them.
- Read pair accepted in IDLE: the state goes to RD. In RD, rf_raddr1/2 carry the command addresses, and rf_rdata1/2 are captured into rsp_data1/2 at the end of RD. The state then goes to RESP with rsp_valid=1 and rsp_last=1. On the response handshake the state returns to IDLE.
- Dump accepted in IDLE: idx is cleared to 0 and the state goes to DUMP_RD.
  - In DUMP_RD, rf_raddr1=idx and rf_raddr2=idx+1; the data is captured and the state goes to DUMP_RESP.
  - On the handshake in DUMP_RESP: if idx == 2^ADDR_WIDTH−2, the state goes to IDLE; otherwise idx += 2 and the state goes to DUMP_RD.
  - A dump produces 2^ADDR_WIDTH/2 responses (16 by default). rsp_last=1 only on the final one.
- Reserved op 11 is accepted and discarded: no register file activity, no response.
- rf_raddr1/2 are 0 outside RD and DUMP_RD.
- rsp_data1/2 and rsp_last stay stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Reset values: all rf_* outputs 0, rsp_valid 0, rsp_data1/2 0, rsp_last 0, busy 0, state IDLE, cmd_ready 1.
- Write: accept at cycle N; rf_wen high during N+1; the register file is updated at the end of N+1.
- Read: accept at N; rf_raddr driven in N+1; rsp_valid rises at N+2. The earliest next accept is the cycle after the response handshake.
- Read-after-write: a read accepted the cycle after a write accept returns the new value. The write lands at the end of N+1 and the read addresses are driven in N+2, so no bypass is needed.
- Dump: each response takes at least 2 cycles (DUMP_RD plus at least one DUMP_RESP cycle). With rsp_ready held at 1, the full 16-response dump takes 32 cycles from accept+1 to the final handshake.
- Reset mid-operation: all state clears immediately. A write whose rf_wen cycle has not yet reached its clock edge is lost. An outstanding response or dump is abandoned with no rsp_valid after release.

## Test plan
- Reset, then write 0xDEADBEEF to r5 and read pair (5,0) → rf_wen high exactly one cycle with waddr 5; response 0xDEADBEEF, 0x00000000, rsp_last=1, rsp_valid at accept+2.
- Back-to-back writes r1=0x11, r2=0x22, then an immediate read (1,2) → three consecutive accepts; response 0x11, 0x22.
- Write 0x12345678 to r0, then read (0,0) → response 0, 0.
- Write rN=N×0x01010101 for N=1..31, then dump with rsp_ready toggling 1/0 → 16 responses; first is (0, 0x01010101), last is (0x1E1E1E1E, 0x1F1F1F1F) with rsp_last=1 only on it; data held stable while stalled; cmd_ready=0 throughout.
- Reserved op 11 → accepted in one cycle; no rf_wen and no rsp_valid; busy stays 0.
- Assert rst_n low during the 5th dump response → outputs return to reset values asynchronously; after release, cmd_ready=1 and no response appears.
